// File: rtl/exec_muldiv_pkg.sv
// Shared op encodings, FSM states and op classification helpers for the execute-stage mul/div unit.
package exec_muldiv_pkg;

  typedef enum logic [2:0] {
    MULDIV_NONE  = 3'd0,
    MULDIV_MULT  = 3'd1,
    MULDIV_MULTU = 3'd2,
    MULDIV_DIV   = 3'd3,
    MULDIV_DIVU  = 3'd4,
    MULDIV_MTHI  = 3'd5,
    MULDIV_MTLO  = 3'd6,
    MULDIV_RSVD  = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_iter_op(input muldiv_op_e op);
    return (op == MULDIV_MULT) || (op == MULDIV_MULTU) ||
           (op == MULDIV_DIV)  || (op == MULDIV_DIVU);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_e op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

  function automatic logic is_div_op(input muldiv_op_e op);
    return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath on unsigned magnitudes: one shift-add or restoring-divide step per cycle.
// The accumulator holds {partial product | multiplier} or {remainder | dividend/quotient}.
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_nxt_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     mul_sum;
  logic [W:0]     shifted;
  logic [W-1:0]   diff;
  logic [W-1:0]   rem_nxt;
  logic           ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Remainder is always below the divisor, so W+1 bits cover the trial value.
    shifted   = acc_q[2*W-1:W-1];
    ge        = (shifted >= {1'b0, b_q});
    diff      = shifted[W-1:0] - b_q;
    rem_nxt   = ge ? diff : shifted[W-1:0];
    acc_nxt_o = div_i ? {rem_nxt, acc_q[W-2:0], ge} : {mul_sum, acc_q[W-1:1]};
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    if (load_i) begin
      acc_d = {{W{1'b0}}, a_i};
      b_d   = b_i;
    end else if (step_i) begin
      acc_d = acc_nxt_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs 32 radix-2 iterations per op and
// holds the pipeline through stall_req while busy; sign handling wraps the unsigned core.
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  stall,
  input  logic [2:0]            op_in,
  input  logic [DATA_WIDTH-1:0] rs_in,
  input  logic [DATA_WIDTH-1:0] rt_in,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  done_out
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

  muldiv_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 neg_qp_q, neg_qp_d, neg_r_q, neg_r_d;
  logic                 div_q, div_d, div0_q, div0_d;
  logic                 core_load, core_step;
  muldiv_op_e           op;
  logic                 sa, sb;
  logic [W-1:0]         abs_a, abs_b;
  logic [2*W-1:0]       acc_nxt, prod_fix;
  logic [W-1:0]         quo_fix, rem_fix;

  always_comb begin
    op    = muldiv_op_e'(op_in);
    sa    = is_signed_op(op) & rs_in[W-1];
    sb    = is_signed_op(op) & rt_in[W-1];
    abs_a = sa ? -rs_in : rs_in;
    abs_b = sb ? -rt_in : rt_in;
  end

  muldiv_iter_core #(.W(W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (core_load),
    .step_i    (core_step),
    .div_i     (div_q),
    .a_i       (abs_a),
    .b_i       (abs_b),
    .acc_nxt_o (acc_nxt)
  );

  // Sign fix-up is applied to the final iteration's combinational result.
  always_comb begin
    prod_fix = neg_qp_q ? -acc_nxt : acc_nxt;
    quo_fix  = div0_q ? '1 : (neg_qp_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0]);
    rem_fix  = neg_r_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    neg_qp_d  = neg_qp_q;
    neg_r_d   = neg_r_q;
    div_d     = div_q;
    div0_d    = div0_q;
    stall_req = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (is_iter_op(op)) begin
            stall_req = 1'b1;
            core_load = 1'b1;
            cnt_d     = '0;
            neg_qp_d  = sa ^ sb;
            neg_r_d   = sa;
            div_d     = is_div_op(op);
            div0_d    = (rt_in == '0);
            state_d   = ST_BUSY;
          end else if (!stall && op == MULDIV_MTHI) begin
            hi_d = rs_in;
          end else if (!stall && op == MULDIV_MTLO) begin
            lo_d = rs_in;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall_req = 1'b1;
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
            if (div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
            else       {hi_d, lo_d} = prod_fix;
          end
        end
      end
      // The completed op may still sit on op_in here, so no accept is possible.
      ST_DONE: begin
        if (flush || !stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      neg_qp_q <= 1'b0;
      neg_r_q  <= 1'b0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      neg_qp_q <= neg_qp_d;
      neg_r_q  <= neg_r_d;
      div_q    <= div_d;
      div0_q   <= div0_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: expected HI/LO go into a scoreboard queue, a monitor pops on done_out.
module tb_exec_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall;
  logic [2:0]  op_in;
  logic [31:0] rs_in, rt_in;
  logic        stall_req, done_out;
  logic [31:0] hi_out, lo_out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [31:0] last_hi, last_lo;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

  always #5 clk = ~clk;

  exec_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stall     (stall),
    .op_in     (op_in),
    .rs_in     (rs_in),
    .rt_in     (rt_in),
    .stall_req (stall_req),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .done_out  (done_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_out) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done_out), 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("result_hi", hi_out, e[63:32]);
        chk("result_lo", lo_out, e[31:0]);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic [63:0] exp);
    int n;
    @(posedge clk); #1;
    op_in = op; rs_in = a; rt_in = b;
    sb.push_back(exp);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    n = 0;
    @(negedge clk);
    while (stall_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, 33);
    chk("done_rise", 32'(done_out), 32'd1);
    if (hold > 0) begin
      stall = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("done_hold_stall_req", 32'(stall_req), 32'd0);
        chk("done_hold_pulse", 32'(done_out), 32'd0);
      end
      stall = 1'b0;
    end
    op_in = OP_NONE;
    @(negedge clk);
    chk("idle_stall_req", 32'(stall_req), 32'd0);
    chk("idle_done", 32'(done_out), 32'd0);
    chk("hi_kept", hi_out, exp[63:32]);
    chk("lo_kept", lo_out, exp[31:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    op_in = OP_NONE; rs_in = '0; rt_in = '0;
    last_hi = '0; last_lo = '0;
    #1;
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(OP_MULT,  32'hFFFFFFFD, 32'd7,        0, 64'hFFFFFFFF_FFFFFFEB);
    run_op(OP_MULTU, 32'h00010000, 32'h00010000, 3, 64'h00000001_00000000);
    run_op(OP_DIVU,  32'd100,      32'd7,        0, {32'd2, 32'd14});
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        0, 64'hFFFFFFFF_FFFFFFFD);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 64'h00000000_80000000);
    run_op(OP_DIVU,  32'd5,        32'd0,        0, 64'h00000005_FFFFFFFF);
    run_op(OP_DIV,   32'hFFFFFFF8, 32'd0,        0, 64'hFFFFFFF8_FFFFFFFF);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE_00000001);
    run_op(OP_MULT,  32'h80000000, 32'h80000000, 0, 64'h40000000_00000000);

    // Flush while BUSY at count 10: no result, HI/LO untouched.
    @(posedge clk); #1;
    op_in = OP_MULTU; rs_in = 32'hFFFFFFFF; rt_in = 32'hFFFFFFFF;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1; op_in = OP_NONE;
    @(negedge clk);
    chk("flush_stall_drop", 32'(stall_req), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_stall_req", 32'(stall_req), 32'd0);
    chk("flush_hi", hi_out, last_hi);
    chk("flush_lo", lo_out, last_lo);
    repeat (40) @(negedge clk);
    chk("flush_no_done", 32'(done_out), 32'd0);
    chk("flush_hi_late", hi_out, last_hi);

    // MTLO is single-cycle with no stall_req.
    @(posedge clk); #1 op_in = OP_MTLO; rs_in = 32'h00001234;
    @(negedge clk);
    chk("mtlo_stall_req", 32'(stall_req), 32'd0);
    @(posedge clk); #1 op_in = OP_NONE;
    @(negedge clk);
    chk("mtlo_lo", lo_out, 32'h00001234);
    chk("mtlo_hi", hi_out, last_hi);

    // MTHI is ignored under an external stall, then applied once the stall clears.
    @(posedge clk); #1 op_in = OP_MTHI; rs_in = 32'h0000ABCD; stall = 1'b1;
    @(posedge clk); #1 op_in = OP_NONE; stall = 1'b0;
    @(negedge clk);
    chk("mthi_stalled", hi_out, last_hi);
    @(posedge clk); #1 op_in = OP_MTHI; rs_in = 32'h0000ABCD;
    @(posedge clk); #1 op_in = OP_NONE;
    @(negedge clk);
    chk("mthi_hi", hi_out, 32'h0000ABCD);
    chk("mthi_lo", lo_out, 32'h00001234);

    // Asynchronous reset at BUSY count 20.
    @(posedge clk); #1;
    op_in = OP_DIVU; rs_in = 32'd1000; rt_in = 32'd3;
    repeat (21) @(posedge clk);
    #1 rst_n = 1'b0; op_in = OP_NONE;
    #1;
    chk("arst_stall_req", 32'(stall_req), 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    chk("arst_done", 32'(done_out), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_stall_req", 32'(stall_req), 32'd0);
    chk("post_rst_hi", hi_out, 32'd0);
    chk("post_rst_lo", lo_out, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
